// File: rtl/seq_divider_param_if.sv
// rtl/seq_divider_param_if.sv - start/busy/done operand and result bundle for seq_divider_param
//
// Purpose: groups the divider's request operands and registered results.
// Ports (signals):
//   start, signed_mode, dividend, divisor    request side, driven by the master
//   quotient, remainder                      registered results, driven by the divider
//   busy, done, div_by_zero, overflow        status, driven by the divider
// Modports: master (controller side), slave (divider side).

interface seq_divider_param_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic             overflow;

  modport master (
    output start, signed_mode, dividend, divisor,
    input  quotient, remainder, busy, done, div_by_zero, overflow
  );

  modport slave (
    input  start, signed_mode, dividend, divisor,
    output quotient, remainder, busy, done, div_by_zero, overflow
  );
endinterface

// File: rtl/seq_divider_param.sv
// rtl/seq_divider_param.sv - parametrised multicycle restoring divider, signed/unsigned per operation
//
// Purpose: divides WIDTH-bit operands one quotient bit per cycle (MSB first).
//   Divide-by-zero and signed MIN/-1 finish on the acceptance edge without
//   iterating; all other operations take WIDTH+1 edges from acceptance to result.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    seq_divider_param_if.slave: start/signed_mode/dividend/divisor in,
//          quotient/remainder/busy/done/div_by_zero/overflow out

module seq_divider_param #(
  parameter int WIDTH = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  seq_divider_param_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  // dvd_q starts as |dividend| and shifts left each step; quotient bits
  // enter at the bottom, so after WIDTH steps it holds the magnitude quotient.
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] rem_q;
  logic             q_neg_q;
  logic             r_neg_q;

  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rmd_q;
  logic             busy_q;
  logic             done_q;
  logic             dz_q;
  logic             ov_q;

  // Operand decode at acceptance
  logic             dvd_sign;
  logic             dvs_sign;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic             is_zero;
  logic             is_ovf;

  assign dvd_sign = bus.signed_mode & bus.dividend[WIDTH-1];
  assign dvs_sign = bus.signed_mode & bus.divisor[WIDTH-1];
  // |MIN| = 2^(WIDTH-1) is representable as an unsigned WIDTH-bit magnitude.
  assign dvd_mag  = dvd_sign ? (~bus.dividend + 1'b1) : bus.dividend;
  assign dvs_mag  = dvs_sign ? (~bus.divisor + 1'b1) : bus.divisor;
  assign is_zero  = (bus.divisor == '0);
  assign is_ovf   = bus.signed_mode && (bus.dividend == MIN_VAL) && (bus.divisor == '1);

  // One restoring step: P = {R, next dividend bit}; subtract if it fits.
  logic [WIDTH:0]   p_d;
  logic [WIDTH:0]   diff_d;
  logic             ge_d;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] dvd_d;
  logic             unused_diff_msb;

  always_comb begin
    p_d    = {rem_q, dvd_q[WIDTH-1]};
    diff_d = p_d - {1'b0, dvs_q};
    ge_d   = (p_d >= {1'b0, dvs_q});
    rem_d  = ge_d ? diff_d[WIDTH-1:0] : p_d[WIDTH-1:0];
    dvd_d  = {dvd_q[WIDTH-2:0], ge_d};
  end

  // The partial remainder after a step is always below the divisor, so the
  // top bit of the kept difference is zero.
  assign unused_diff_msb = diff_d[WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      quo_q   <= '0;
      rmd_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            dz_q <= 1'b0;
            ov_q <= 1'b0;
            if (is_zero) begin
              quo_q  <= '1;
              rmd_q  <= bus.dividend;
              dz_q   <= 1'b1;
              done_q <= 1'b1;
            end else if (is_ovf) begin
              quo_q  <= MIN_VAL;
              rmd_q  <= '0;
              ov_q   <= 1'b1;
              done_q <= 1'b1;
            end else begin
              dvd_q   <= dvd_mag;
              dvs_q   <= dvs_mag;
              rem_q   <= '0;
              q_neg_q <= dvd_sign ^ dvs_sign;
              r_neg_q <= dvd_sign;
              cnt_q   <= CNT_W'(WIDTH);
              busy_q  <= 1'b1;
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          dvd_q <= dvd_d;
          rem_q <= rem_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          // Sign fix-up: quotient truncates toward zero, remainder follows dividend.
          quo_q   <= q_neg_q ? (~dvd_q + 1'b1) : dvd_q;
          rmd_q   <= r_neg_q ? (~rem_q + 1'b1) : rem_q;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.quotient    = quo_q;
  assign bus.remainder   = rmd_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dz_q;
  assign bus.overflow    = ov_q;

endmodule

// File: tb/tb_seq_divider_param.sv
// tb/tb_seq_divider_param.sv - bench for seq_divider_param at WIDTH 8, 4 and 16

module tb_seq_divider_param;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seq_divider_param_if #(.WIDTH(8))  if8 ();
  seq_divider_param_if #(.WIDTH(4))  if4 ();
  seq_divider_param_if #(.WIDTH(16)) if16 ();

  seq_divider_param #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
  seq_divider_param #(.WIDTH(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
  seq_divider_param #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16.slave));

  int vectors = 0;
  int miscompares = 0;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division in the operand's number system.
  function automatic void ref_div(input int w, input bit sm, input logic [63:0] a, input logic [63:0] b,
                                  output logic [63:0] q, output logic [63:0] r, output bit dz, output bit ov);
    logic [63:0] mask;
    longint sa, sb;
    mask = (64'd1 << w) - 64'd1;
    sa = longint'(a);
    sb = longint'(b);
    if (sm && a[w-1]) sa = sa - (longint'(1) << w);
    if (sm && b[w-1]) sb = sb - (longint'(1) << w);
    dz = 1'b0;
    ov = 1'b0;
    if (b == 64'd0) begin
      q = mask; r = a; dz = 1'b1;
    end else if (sm && sa == -(longint'(1) << (w - 1)) && sb == -1) begin
      q = 64'd1 << (w - 1); r = 64'd0; ov = 1'b1;
    end else begin
      q = 64'(sa / sb) & mask;
      r = 64'(sa % sb) & mask;
    end
  endfunction

  task automatic check_op(input string tag, input int w, input bit sm, input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] q, input logic [63:0] r, input logic dz, input logic ov,
                          input int lat, input int bcnt, input bit seen);
    logic [63:0] eq, er;
    bit edz, eov;
    int elat;
    ref_div(w, sm, a, b, eq, er, edz, eov);
    elat = (edz || eov) ? 0 : w + 1;
    chk($sformatf("%s done_seen", tag), 64'(seen), 64'd1);
    chk($sformatf("%s quotient %0h/%0h sm=%0d", tag, a, b, sm), q, eq);
    chk($sformatf("%s remainder %0h/%0h sm=%0d", tag, a, b, sm), r, er);
    chk($sformatf("%s div_by_zero", tag), 64'(dz), 64'(edz));
    chk($sformatf("%s overflow", tag), 64'(ov), 64'(eov));
    chk($sformatf("%s latency", tag), 64'(lat), 64'(elat));
    chk($sformatf("%s busy_cycles", tag), 64'(bcnt), 64'(elat));
  endtask

  // Each run task is entered mid low phase, drives start across one rising
  // edge, scrambles the operands, then returns at the low phase where done is seen.
  task automatic run8(input bit sm, input logic [7:0] a, input logic [7:0] b,
                      output logic [63:0] q, output logic [63:0] r, output logic dz, output logic ov,
                      output int lat, output int bcnt, output bit seen);
    if8.start = 1'b1; if8.signed_mode = sm; if8.dividend = a; if8.divisor = b;
    @(posedge clk); #1;
    if8.start = 1'b0; if8.dividend = 8'($urandom); if8.divisor = 8'($urandom); if8.signed_mode = ~sm;
    lat = 0; bcnt = 0; seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (if8.busy) bcnt++;
      if (if8.done) begin seen = 1'b1; lat = k; break; end
    end
    q = 64'(if8.quotient); r = 64'(if8.remainder); dz = if8.div_by_zero; ov = if8.overflow;
  endtask

  task automatic run4(input bit sm, input logic [3:0] a, input logic [3:0] b,
                      output logic [63:0] q, output logic [63:0] r, output logic dz, output logic ov,
                      output int lat, output int bcnt, output bit seen);
    if4.start = 1'b1; if4.signed_mode = sm; if4.dividend = a; if4.divisor = b;
    @(posedge clk); #1;
    if4.start = 1'b0; if4.dividend = 4'($urandom); if4.divisor = 4'($urandom);
    lat = 0; bcnt = 0; seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (if4.busy) bcnt++;
      if (if4.done) begin seen = 1'b1; lat = k; break; end
    end
    q = 64'(if4.quotient); r = 64'(if4.remainder); dz = if4.div_by_zero; ov = if4.overflow;
  endtask

  task automatic run16(input bit sm, input logic [15:0] a, input logic [15:0] b,
                       output logic [63:0] q, output logic [63:0] r, output logic dz, output logic ov,
                       output int lat, output int bcnt, output bit seen);
    if16.start = 1'b1; if16.signed_mode = sm; if16.dividend = a; if16.divisor = b;
    @(posedge clk); #1;
    if16.start = 1'b0; if16.dividend = 16'($urandom); if16.divisor = 16'($urandom);
    lat = 0; bcnt = 0; seen = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (if16.busy) bcnt++;
      if (if16.done) begin seen = 1'b1; lat = k; break; end
    end
    q = 64'(if16.quotient); r = 64'(if16.remainder); dz = if16.div_by_zero; ov = if16.overflow;
  endtask

  typedef struct {
    bit         sm;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
  } dir_t;

  initial begin
    dir_t dirs[$];
    logic [63:0] q, r;
    logic dz, ov;
    int lat, bcnt, dcnt;
    bit seen, sm;
    logic [7:0] a8, b8;
    logic [15:0] a16, b16;

    if8.start = 1'b0;  if8.signed_mode = 1'b0;  if8.dividend = '0;  if8.divisor = '0;
    if4.start = 1'b0;  if4.signed_mode = 1'b0;  if4.dividend = '0;  if4.divisor = '0;
    if16.start = 1'b0; if16.signed_mode = 1'b0; if16.dividend = '0; if16.divisor = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset quotient", 64'(if8.quotient), 64'd0);
    chk("reset remainder", 64'(if8.remainder), 64'd0);
    chk("reset busy", 64'(if8.busy), 64'd0);
    chk("reset done", 64'(if8.done), 64'd0);
    chk("reset flags", 64'({if8.div_by_zero, if8.overflow}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed WIDTH=8 cases, issued back to back (each start in the done cycle)
    dirs.push_back('{1'b0, 8'd200, 8'd7,  8'd28,  8'd4});
    dirs.push_back('{1'b1, 8'hF9,  8'h02, 8'hFD,  8'hFF});
    dirs.push_back('{1'b1, 8'h07,  8'hFE, 8'hFD,  8'h01});
    dirs.push_back('{1'b1, 8'hF9,  8'hFE, 8'h03,  8'hFF});
    dirs.push_back('{1'b0, 8'h55,  8'h00, 8'hFF,  8'h55});
    dirs.push_back('{1'b1, 8'h55,  8'h00, 8'hFF,  8'h55});
    dirs.push_back('{1'b1, 8'h80,  8'hFF, 8'h80,  8'h00});
    dirs.push_back('{1'b0, 8'h80,  8'hFF, 8'h00,  8'h80});
    dirs.push_back('{1'b1, 8'h80,  8'h01, 8'h80,  8'h00});
    dirs.push_back('{1'b0, 8'h10,  8'h03, 8'h05,  8'h01});
    foreach (dirs[i]) begin
      run8(dirs[i].sm, dirs[i].a, dirs[i].b, q, r, dz, ov, lat, bcnt, seen);
      chk($sformatf("dir%0d quotient", i), q, 64'(dirs[i].q));
      chk($sformatf("dir%0d remainder", i), r, 64'(dirs[i].r));
      check_op($sformatf("dir%0d", i), 8, dirs[i].sm, 64'(dirs[i].a), 64'(dirs[i].b), q, r, dz, ov, lat, bcnt, seen);
    end

    // done is a single-cycle pulse and results hold afterwards
    @(negedge clk);
    chk("done pulse width", 64'(if8.done), 64'd0);
    repeat (3) @(negedge clk);
    chk("hold quotient", 64'(if8.quotient), 64'h05);
    chk("hold remainder", 64'(if8.remainder), 64'h01);

    // start pulses at cycles 3 and 5 of a run are ignored
    if8.start = 1'b1; if8.signed_mode = 1'b0; if8.dividend = 8'd200; if8.divisor = 8'd7;
    @(posedge clk); #1;
    if8.start = 1'b0;
    seen = 1'b0; lat = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k == 2 || k == 4) begin
        if8.start = 1'b1; if8.dividend = 8'h11; if8.divisor = 8'h03;
      end else begin
        if8.start = 1'b0;
      end
      if (k == 6) chk("no intermediate quotient", 64'(if8.quotient), 64'h05);
      if (if8.done) begin seen = 1'b1; lat = k; break; end
    end
    if8.start = 1'b0;
    chk("ignore done_seen", 64'(seen), 64'd1);
    chk("ignore latency", 64'(lat), 64'd9);
    chk("ignore quotient", 64'(if8.quotient), 64'd28);
    chk("ignore remainder", 64'(if8.remainder), 64'd4);
    @(negedge clk);
    chk("ignore no second run", 64'({if8.busy, if8.done}), 64'd0);

    // Asynchronous reset at cycle 4 of a run aborts with no done
    if8.start = 1'b1; if8.signed_mode = 1'b1; if8.dividend = 8'hF9; if8.divisor = 8'h02;
    @(posedge clk); #1;
    if8.start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort quotient", 64'(if8.quotient), 64'd0);
    chk("abort remainder", 64'(if8.remainder), 64'd0);
    chk("abort status", 64'({if8.busy, if8.done, if8.div_by_zero, if8.overflow}), 64'd0);
    dcnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (if8.done) dcnt++;
    end
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (if8.done || if8.busy) dcnt++;
    end
    chk("abort no done", 64'(dcnt), 64'd0);
    run8(1'b0, 8'hE7, 8'h0C, q, r, dz, ov, lat, bcnt, seen);
    chk("after reset quotient", q, 64'd19);
    chk("after reset remainder", r, 64'd3);
    check_op("after reset", 8, 1'b0, 64'hE7, 64'h0C, q, r, dz, ov, lat, bcnt, seen);

    // Random WIDTH=8 in both modes, including zero divisor and MIN/-1
    for (int i = 0; i < 120; i++) begin
      sm = 1'($urandom);
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      case ($urandom_range(0, 9))
        0: b8 = 8'h00;
        1: begin a8 = 8'h80; b8 = 8'hFF; end
        2: b8 = 8'h01;
        default: ;
      endcase
      run8(sm, a8, b8, q, r, dz, ov, lat, bcnt, seen);
      check_op("rand8", 8, sm, 64'(a8), 64'(b8), q, r, dz, ov, lat, bcnt, seen);
    end

    // Exhaustive WIDTH=4
    for (int m = 0; m < 2; m++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          run4(1'(m), 4'(a), 4'(b), q, r, dz, ov, lat, bcnt, seen);
          check_op("exh4", 4, 1'(m), 64'(a), 64'(b), q, r, dz, ov, lat, bcnt, seen);
        end
      end
    end

    // Random WIDTH=16
    for (int i = 0; i < 150; i++) begin
      sm = 1'($urandom);
      a16 = 16'($urandom);
      b16 = 16'($urandom);
      case ($urandom_range(0, 9))
        0: b16 = 16'h0000;
        1: begin a16 = 16'h8000; b16 = 16'hFFFF; end
        2: b16 = 16'($urandom_range(1, 15));
        3: b16 = 16'hFFFF;
        default: ;
      endcase
      run16(sm, a16, b16, q, r, dz, ov, lat, bcnt, seen);
      check_op("rand16", 16, sm, 64'(a16), 64'(b16), q, r, dz, ov, lat, bcnt, seen);
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
